// File: rtl/uart_rx_core.sv
// UART receiver core: two-flop line synchronizer, mid-bit sampling FSM, 8N1 framing.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a PARITY state and parity_err reporting.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a low level
  // START     | half a bit time into the start bit, confirm it is still low
  // DATA      | sample 8 data bits, LSB first, one bit time apart
  // PARITY    | sample even-parity bit (parity build only)
  // STOP      | sample stop bit, publish byte or flag framing error
  // WAIT_HIGH | line stuck low after a bad stop bit, wait for it to go high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_TC = CW'((CLKS_PER_BIT / 2) - 1);

  logic          rxd_meta;
  logic          rxd_sync;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          baud_tc;
  logic          counting;
  logic          byte_ok;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  assign baud_tc  = (state == START) ? (baud_cnt == HALF_TC) : (baud_cnt == FULL_TC);
  assign counting = (state != IDLE) && (state != WAIT_HIGH);
  assign rx_busy  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == IDLE) begin
        par_bad <= 1'b0;
      end else if (state == PARITY && baud_tc) begin
        par_bad    <= (rxd_sync != (^shift_q));
        parity_err <= (rxd_sync != (^shift_q));
      end
    end
  end

  assign byte_ok = !par_bad;
`else
  assign parity_err = 1'b0;
  assign byte_ok    = 1'b1;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_q   <= 8'h00;
      rx_data   <= 8'h00;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_status <= 1'b0;
      frame_err <= 1'b0;
      if (counting) begin
        baud_cnt <= baud_tc ? '0 : baud_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (!rxd_sync) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
          end
        end
        START: begin
          if (baud_tc) begin
            state <= rxd_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (baud_tc) begin
            shift_q <= {rxd_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tc) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tc) begin
            if (rxd_sync) begin
              // A frame with bad parity is consumed here without publishing it.
              if (byte_ok) begin
                rx_data   <= shift_q;
                rx_status <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_sync) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLKS_PER_BIT=16 with a queue-based frame model.
// Build with UART_RX_PARITY_EN defined to also exercise the 8E1 variant.
module tb_uart_rx_core;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EXTRA = CPB;
`else
  localparam int PAR_EXTRA = 0;
`endif

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_status = 0;
  int n_ferr = 0;
  int n_perr = 0;

  // kind: 0 = byte received, 1 = framing error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t0;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       prev_any = 1'b0;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Queues the expected outcome, then plays the frame onto the line.
  task automatic send(input logic [7:0] d, input bit bad_par, input logic stop_v, input int stop_bits);
    ev_t e;
    e.data = d;
    e.t0   = cyc;
    if (bad_par) e.kind = 2;
    else if (stop_v) e.kind = 0;
    else e.kind = 1;
    exp_q.push_back(e);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ bad_par, CPB);
`endif
    drive(stop_v, CPB * stop_bits);
  endtask

  always @(negedge sysclk) begin
    if (reset) begin
      n_status += int'(rx_status);
      n_ferr   += int'(frame_err);
      n_perr   += int'(parity_err);
    end
  end

  always @(negedge sysclk) begin
    logic any;
    ev_t  e;
    int   kind_act;
    int   lat;
    int   lo;
    int   hi;
    if (!reset) begin
      check("reset_outputs", int'({rx_data, rx_status, frame_err, parity_err, rx_busy}), 0);
      prev_any = 1'b0;
    end else begin
      any = rx_status | frame_err | parity_err;
      check_rng("pulse_exclusive", int'(rx_status) + int'(frame_err) + int'(parity_err), 0, 1);
      if (any) begin
        check("pulse_repeat", int'(prev_any), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'({rx_status, frame_err, parity_err}), 0);
        end else begin
          e = exp_q.pop_front();
          kind_act = rx_status ? 0 : (frame_err ? 1 : 2);
          check("pulse_kind", kind_act, e.kind);
          lat = cyc - e.t0;
          lo  = 148 + ((e.kind == 2) ? 0 : PAR_EXTRA);
          hi  = 156 + ((e.kind == 2) ? 0 : PAR_EXTRA);
          check_rng("pulse_latency", lat, lo, hi);
          if (e.kind == 0) model_data = e.data;
        end
      end
      check("rx_data_model", int'(rx_data), int'(model_data));
      prev_any = any;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    int  fell;
    bit  saw;

    repeat (3) @(posedge sysclk);
    #1;
    check("rst_rx_data", int'(rx_data), 8'h00);
    check("rst_busy", int'(rx_busy), 0);
    reset = 1'b1;
    drive(1'b1, 20);

    send(8'h55, 1'b0, 1'b1, 1);
    drive(1'b1, 20);
    check("f55_data", int'(rx_data), 8'h55);
    check("f55_status_cnt", n_status, 1);
    check("f55_busy_after", int'(rx_busy), 0);

    t0 = cyc;
    drive(1'b0, 4);
    uart_rxd = 1'b1;
    saw = 1'b0;
    fell = -1;
    for (int i = 0; i < 30 && fell < 0; i++) begin
      @(negedge sysclk);
      if (rx_busy) saw = 1'b1;
      else if (saw) fell = cyc - t0;
    end
    check("glitch_busy_seen", int'(saw), 1);
    check_rng("glitch_busy_fall", fell, 0, 11);
    @(posedge sysclk);
    #1;
    drive(1'b1, 20);
    check("glitch_no_status", n_status, 1);
    check("glitch_no_ferr", n_ferr, 0);

    send(8'hA3, 1'b0, 1'b0, 40);
    check("break_busy_held", int'(rx_busy), 1);
    uart_rxd = 1'b1;
    t0 = cyc;
    fell = -1;
    for (int i = 0; i < 10 && fell < 0; i++) begin
      @(negedge sysclk);
      if (!rx_busy) fell = cyc - t0;
    end
    check_rng("break_release", fell, 0, 4);
    @(posedge sysclk);
    #1;
    drive(1'b1, 20);
    check("break_ferr_cnt", n_ferr, 1);
    check("break_data_kept", int'(rx_data), 8'h55);

    send(8'h00, 1'b0, 1'b1, 1);
    send(8'hFF, 1'b0, 1'b1, 1);
    drive(1'b1, 20);
    check("b2b_status_cnt", n_status, 3);
    check("b2b_last_data", int'(rx_data), 8'hFF);

    drive(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(1'b1, CPB);
    drive(1'b1, CPB / 2);
    reset = 1'b0;
    exp_q.delete();
    model_data = 8'h00;
    drive(1'b1, 3);
    check("midrst_data", int'(rx_data), 8'h00);
    check("midrst_busy", int'(rx_busy), 0);
    reset = 1'b1;
    drive(1'b1, CPB * 6);
    check("midrst_no_pulse", n_status, 3);
    check("midrst_idle", int'(rx_busy), 0);
    send(8'h3C, 1'b0, 1'b1, 1);
    drive(1'b1, 20);
    check("f3c_data", int'(rx_data), 8'h3C);
    check("f3c_status_cnt", n_status, 4);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 1);
    drive(1'b1, 20);
    check("par_bad_cnt", n_perr, 1);
    check("par_bad_data", int'(rx_data), 8'h3C);
    send(8'h07, 1'b0, 1'b1, 1);
    drive(1'b1, 20);
    check("par_ok_data", int'(rx_data), 8'h07);
    check("par_ok_status_cnt", n_status, 5);
`else
    check("noparity_err_cnt", n_perr, 0);
`endif

    check("events_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning sysclk cycles per bit (9600 baud at 100 MHz); legal range 4..65535.
REQ-002 The block SHALL have port sysclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high, 8N1 LSB first.
REQ-005 The block SHALL have port rx_data, output, 8 bits: last correctly received byte.
REQ-006 The block SHALL have port rx_status, output, 1 bit: one-cycle pulse when rx_data has just been updated.
REQ-007 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-009 The block SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 uart_rxd SHALL pass through a two-flop synchronizer, reset to 1, before any use; all sampling uses the synchronized value.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (parity build only), STOP and WAIT_HIGH.
REQ-012 IDLE -> START SHALL occur on the first cycle the synchronized line is 0; bit counter cleared, baud counter loaded with 0.
REQ-013 In START, after CLKS_PER_BIT/2 (integer division) cycles, the line SHALL be resampled: 0 -> DATA; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 In DATA, each bit SHALL be sampled after exactly CLKS_PER_BIT cycles from the previous sample, shifted in LSB first; after the 8th bit -> PARITY if compiled in, else STOP.
REQ-015 In STOP, one bit time after the last sample: line 1 -> rx_data loaded and rx_status pulsed on the next rising edge, then IDLE; line 0 -> frame_err pulsed, rx_data unchanged, then WAIT_HIGH.
REQ-016 WAIT_HIGH SHALL return to IDLE on the first cycle the synchronized line is 1, so a break condition yields exactly one frame_err.
REQ-017 Baud counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits; it SHALL count to CLKS_PER_BIT-1 and wrap to 0 without overflow.
REQ-018 rx_status, frame_err and parity_err SHALL be mutually exclusive and never high for more than one consecutive cycle.
REQ-019 Back-to-back frames (next start edge directly after the stop bit) SHALL be received without loss, since STOP exits at stop-bit midpoint.
REQ-020 Sampling latency: rx_status SHALL rise within 9.5*CLKS_PER_BIT+4 cycles of the falling start edge on uart_rxd.

Reset
REQ-021 On reset low, asynchronously: FSM=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_status=0, frame_err=0, parity_err=0, rx_busy=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception restarts only on a new falling edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: the frame SHALL be 8E1; PARITY samples one bit time after bit 7; mismatch with even parity of the data -> parity_err pulse, rx_data unchanged, then STOP consumed without updating rx_data; match -> STOP as in REQ-015.
REQ-024 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is 8N1, parity_err tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-025 Frame 0x55 with valid stop -> rx_data=0x55, single rx_status pulse, rx_busy low afterwards.
REQ-026 Low glitch of 4 cycles on idle line -> no rx_status/frame_err, rx_busy falls within 8+3 cycles.
REQ-027 After 0x55 received, frame 0xA3 with stop bit 0 and line held low 40 bit times -> exactly one frame_err, rx_data stays 0x55.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two rx_status pulses, rx_data 0x00 then 0xFF.
REQ-029 Reset pulsed low during data bit 3 of a frame -> all outputs at reset values, no pulse; next frame 0x3C received correctly.
REQ-030 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, rx_data unchanged; with parity bit 1 -> rx_data=0x07, rx_status pulse.
